// File: rtl/pcie_framing_pkg.sv
// Shared framing definitions for the 128b/130b RX deframer.
// Contents: token byte constants, the first symbol index at which EDS may
// start, sync-header encodings, the deframer state enum, and a lookup of the
// expected EDS byte by position.
package pcie_framing_pkg;

  localparam logic [3:0] STP_NIBBLE       = 4'hF;
  localparam logic [7:0] SDP_B0           = 8'hF0;
  localparam logic [7:0] SDP_B1           = 8'hAC;
  localparam logic [7:0] EDS_B0           = 8'h1F;
  localparam logic [7:0] EDS_B1           = 8'h80;
  localparam logic [7:0] EDS_B2           = 8'h90;
  localparam logic [7:0] EDS_B3           = 8'h00;
  localparam logic [7:0] IDL              = 8'h00;
  localparam logic [3:0] EDS_START_SYMBOL = 4'd12;
  localparam logic       SYNC_H_DATA      = 1'b0;
  localparam logic       SYNC_H_OS        = 1'b1;

  typedef enum logic [3:0] {
    ST_RESET     = 4'd0,
    ST_TOKENS    = 4'd1,
    ST_STP       = 4'd2,
    ST_SDP       = 4'd3,
    ST_EDS       = 4'd4,
    ST_TLP_DATA  = 4'd5,
    ST_DLLP_DATA = 4'd6,
    ST_OS_WAIT   = 4'd7,
    ST_ERR_WAIT  = 4'd8
  } state_t;

  // Expected EDS byte at token position idx (0 = first byte).
  function automatic logic [7:0] eds_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    eds_byte = EDS_B0;
      2'd1:    eds_byte = EDS_B1;
      2'd2:    eds_byte = EDS_B2;
      default: eds_byte = EDS_B3;
    endcase
  endfunction

endpackage

// File: rtl/deframing_symbol_counter.sv
// Payload symbol down-counter for the deframer.
// Ports:
//   clk, rst_n  : clock, async active-low reset (count clears to 0)
//   load        : load load_val this cycle (has priority over en)
//   load_val    : number of payload symbols in the packet
//   en          : one payload symbol consumed this cycle
//   done        : the symbol being consumed now is the last one (count == 1)
module deframing_symbol_counter #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/deframing_fsm_one_lane.sv
// One-lane RX deframer: parses IDL/STP/SDP/EDS tokens from descrambled
// symbols, strips them, and streams TLP/DLLP payload with SOP/EOP/type/length.
// Ports:
//   CLK, RST_L        : clock, async active-low reset
//   i_EN              : symbol valid; low stalls everything, pulses read 0
//   i_Symbol          : received symbol
//   i_Sync_Hdr        : 0 data block, 1 ordered-set block
//   i_Symbol_Num      : symbol index within its 16-symbol block
//   o_Data/o_Data_Valid, o_SOP, o_EOP, o_Type, o_Length : payload stream
//   o_Idle_Indicator  : IDL seen while parsing tokens
//   o_Os_Expected     : EDS complete, next block must be an ordered set
//   o_Framing_Err     : framing violation pulse
//   o_State           : current FSM state (debug)
// Handshake: there is no backpressure. A symbol is consumed on every rising
// edge with i_EN=1, and its result is presented on the outputs for exactly
// the following cycle; o_Data_Valid qualifies o_Data/o_Type, o_SOP qualifies
// o_Length.
module deframing_fsm_one_lane
  import pcie_framing_pkg::*;
#(
  parameter int SYMBOL_WIDTH     = 8,
  parameter int PACKET_LENGTH    = 11,
  parameter int SYMBOL_NUM_WIDTH = 4,
  parameter int DLLP_DATA_DIPTH  = 6
) (
  input  logic                        CLK,
  input  logic                        RST_L,
  input  logic                        i_EN,
  input  logic [SYMBOL_WIDTH-1:0]     i_Symbol,
  input  logic                        i_Sync_Hdr,
  input  logic [SYMBOL_NUM_WIDTH-1:0] i_Symbol_Num,
  output logic [SYMBOL_WIDTH-1:0]     o_Data,
  output logic                        o_Data_Valid,
  output logic                        o_SOP,
  output logic                        o_EOP,
  output logic                        o_Type,
  output logic [PACKET_LENGTH-1:0]    o_Length,
  output logic                        o_Idle_Indicator,
  output logic                        o_Os_Expected,
  output logic                        o_Framing_Err,
  output state_t                      o_State
);

  // Length*4 always fits in PACKET_LENGTH+2 bits, so Length*4-4 cannot wrap.
  localparam int CNT_W = PACKET_LENGTH + 2;

  state_t                   state;
  logic [1:0]               tok_idx;     // position within a 4-byte token
  logic [PACKET_LENGTH-1:0] length_q;
  logic                     first;       // next payload byte carries SOP
  logic                     os_pending;  // EDS seen, waiting for OS block

  logic             sync_os, sym0, tok_ok, parse_tok, err;
  logic             cnt_load, cnt_en, cnt_done;
  logic [CNT_W-1:0] cnt_load_val;

  assign sync_os = (i_Sync_Hdr == SYNC_H_OS);
  assign sym0    = (i_Symbol_Num == '0);
  // 1Fh is EDS only at its start slot; its low nibble must not be read as STP.
  assign tok_ok  = (i_Symbol == IDL) || (i_Symbol == SDP_B0) ||
                   ((i_Symbol == EDS_B0) ? (i_Symbol_Num == EDS_START_SYMBOL)
                                         : (i_Symbol[3:0] == STP_NIBBLE));
  // The first data symbol 0 after ordered sets is parsed as a token directly.
  assign parse_tok = !sync_os &&
                     ((state == ST_TOKENS) ||
                      ((state == ST_OS_WAIT) && sym0 && !os_pending));
  assign o_State = state;

  always_comb begin
    err          = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    if (i_EN) begin
      case (state)
        ST_TOKENS:  if (sync_os || !tok_ok) err = 1'b1;
        ST_OS_WAIT: if (!sync_os && sym0 && (os_pending || !tok_ok)) err = 1'b1;
        ST_STP: begin
          if (sync_os) begin
            err = 1'b1;
          end else if (tok_idx == 2'd3) begin
            if (length_q < PACKET_LENGTH'(5)) begin
              err = 1'b1;
            end else begin
              cnt_load     = 1'b1;
              cnt_load_val = {length_q, 2'b00} - CNT_W'(4);
            end
          end
        end
        ST_SDP: begin
          if (sync_os || (i_Symbol != SDP_B1)) begin
            err = 1'b1;
          end else begin
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(DLLP_DATA_DIPTH);
          end
        end
        ST_EDS:     if (i_Symbol != eds_byte(tok_idx)) err = 1'b1;
        ST_TLP_DATA, ST_DLLP_DATA: begin
          if (sync_os) err = 1'b1;
          else         cnt_en = 1'b1;
        end
        default: ;
      endcase
    end
  end

  deframing_symbol_counter #(.W(CNT_W)) u_counter (
    .clk      (CLK),
    .rst_n    (RST_L),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .done     (cnt_done)
  );

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      state            <= ST_RESET;
      tok_idx          <= 2'd0;
      length_q         <= '0;
      first            <= 1'b0;
      os_pending       <= 1'b0;
      o_Data           <= '0;
      o_Data_Valid     <= 1'b0;
      o_SOP            <= 1'b0;
      o_EOP            <= 1'b0;
      o_Type           <= 1'b0;
      o_Length         <= '0;
      o_Idle_Indicator <= 1'b0;
      o_Os_Expected    <= 1'b0;
      o_Framing_Err    <= 1'b0;
    end else begin
      o_Data           <= '0;
      o_Data_Valid     <= 1'b0;
      o_SOP            <= 1'b0;
      o_EOP            <= 1'b0;
      o_Type           <= 1'b0;
      o_Length         <= '0;
      o_Idle_Indicator <= 1'b0;
      o_Os_Expected    <= 1'b0;
      o_Framing_Err    <= 1'b0;
      if (i_EN) begin
        if (err) begin
          o_Framing_Err <= 1'b1;
          // Close a partial packet so the RX buffer can drop it.
          o_EOP         <= (state == ST_TLP_DATA) || (state == ST_DLLP_DATA);
          os_pending    <= 1'b0;
          state         <= ST_ERR_WAIT;
        end else if (parse_tok) begin
          if (i_Symbol == IDL) begin
            o_Idle_Indicator <= 1'b1;
            state            <= ST_TOKENS;
          end else if (i_Symbol == SDP_B0) begin
            state <= ST_SDP;
          end else if (i_Symbol == EDS_B0) begin
            state   <= ST_EDS;
            tok_idx <= 2'd1;
          end else begin
            state         <= ST_STP;
            tok_idx       <= 2'd1;
            length_q[3:0] <= i_Symbol[7:4];
          end
        end else begin
          case (state)
            ST_RESET:   state <= ST_OS_WAIT;
            ST_OS_WAIT: if (sync_os) os_pending <= 1'b0;
            ST_STP: begin
              if (tok_idx == 2'd1) length_q[PACKET_LENGTH-1:4] <= i_Symbol[PACKET_LENGTH-5:0];
              if (tok_idx == 2'd3) begin
                state <= ST_TLP_DATA;
                first <= 1'b1;
              end else begin
                tok_idx <= tok_idx + 2'd1;
              end
            end
            ST_SDP: begin
              state <= ST_DLLP_DATA;
              first <= 1'b1;
            end
            ST_EDS: begin
              if (tok_idx == 2'd3) begin
                o_Os_Expected <= 1'b1;
                os_pending    <= 1'b1;
                state         <= ST_OS_WAIT;
              end else begin
                tok_idx <= tok_idx + 2'd1;
              end
            end
            ST_TLP_DATA, ST_DLLP_DATA: begin
              o_Data       <= i_Symbol;
              o_Data_Valid <= 1'b1;
              o_Type       <= (state == ST_TLP_DATA);
              o_SOP        <= first;
              o_Length     <= (first && (state == ST_TLP_DATA)) ? length_q : '0;
              first        <= 1'b0;
              if (cnt_done) begin
                o_EOP <= 1'b1;
                state <= ST_TOKENS;
              end
            end
            ST_ERR_WAIT: if (sync_os && sym0) state <= ST_OS_WAIT;
            default:     state <= ST_RESET;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_deframing_fsm_one_lane.sv
module tb_deframing_fsm_one_lane;
  import pcie_framing_pkg::*;

  localparam int EW = 26;  // {valid, data[8], sop, eop, type, length[11], idle, os_exp, err}

  typedef struct {
    logic          en;
    logic [7:0]    sym;
    logic          sync;
    logic [3:0]    num;
    logic [EW-1:0] exp;
  } vec_t;

  localparam logic [EW-1:0] E_NONE    = '0;
  localparam logic [EW-1:0] E_IDLE    = 26'b100;
  localparam logic [EW-1:0] E_OSX     = 26'b010;
  localparam logic [EW-1:0] E_ERR     = 26'b001;
  localparam logic [EW-1:0] E_ERR_EOP = {1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 11'd0, 3'b001};

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        RST_L = 1'b0;
  logic        i_EN = 1'b0;
  logic [7:0]  i_Symbol = 8'h00;
  logic        i_Sync_Hdr = 1'b0;
  logic [3:0]  i_Symbol_Num = 4'd0;
  logic [7:0]  o_Data;
  logic        o_Data_Valid, o_SOP, o_EOP, o_Type;
  logic [10:0] o_Length;
  logic        o_Idle_Indicator, o_Os_Expected, o_Framing_Err;
  state_t      o_State;

  always #5 CLK = ~CLK;

  deframing_fsm_one_lane dut (
    .CLK              (CLK),
    .RST_L            (RST_L),
    .i_EN             (i_EN),
    .i_Symbol         (i_Symbol),
    .i_Sync_Hdr       (i_Sync_Hdr),
    .i_Symbol_Num     (i_Symbol_Num),
    .o_Data           (o_Data),
    .o_Data_Valid     (o_Data_Valid),
    .o_SOP            (o_SOP),
    .o_EOP            (o_EOP),
    .o_Type           (o_Type),
    .o_Length         (o_Length),
    .o_Idle_Indicator (o_Idle_Indicator),
    .o_Os_Expected    (o_Os_Expected),
    .o_Framing_Err    (o_Framing_Err),
    .o_State          (o_State)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  vec_t          vecs[$];
  logic [3:0]    cur_num = 4'd0;
  int            n_checks = 0;
  int            n_errors = 0;

  function automatic logic [EW-1:0] outs();
    return {o_Data_Valid, o_Data, o_SOP, o_EOP, o_Type, o_Length,
            o_Idle_Indicator, o_Os_Expected, o_Framing_Err};
  endfunction

  function automatic logic [EW-1:0] e_byte(input logic [7:0] d, input logic sop,
                                           input logic eop, input logic typ,
                                           input logic [10:0] len);
    return {1'b1, d, sop, eop, typ, len, 3'b000};
  endfunction

  function automatic vec_t mk(input logic en, input logic [7:0] sym, input logic sync,
                              input logic [3:0] num, input logic [EW-1:0] exp);
    vec_t v;
    v.en = en; v.sym = sym; v.sync = sync; v.num = num; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic apply(input vec_t v, input string nm);
    logic [EW-1:0] e;
    @(negedge CLK);
    i_EN = v.en; i_Symbol = v.sym; i_Sync_Hdr = v.sync; i_Symbol_Num = v.num;
    exp_q.push_back(v.exp);
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    chk(nm, 32'(outs()), 32'(e));
  endtask

  // Table builders: cur_num tracks the block position of enabled symbols.
  task automatic add(input logic en, input logic [7:0] sym, input logic sync,
                     input logic [EW-1:0] exp);
    vecs.push_back(mk(en, sym, sync, cur_num, exp));
    if (en) cur_num = cur_num + 4'd1;
  endtask

  task automatic add_fill(input int n, input logic [7:0] sym, input logic sync,
                          input logic [EW-1:0] exp);
    for (int i = 0; i < n; i++) add(1'b1, sym, sync, exp);
  endtask

  task automatic add_payload(input logic [7:0] base, input int n, input logic typ,
                             input logic [10:0] len);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = base + 8'(i);
      add(1'b1, d, SYNC_H_DATA, e_byte(d, i == 0, i == n - 1, typ, (i == 0) ? len : 11'd0));
    end
  endtask

  task automatic add_eds();
    add(1'b1, 8'h1F, SYNC_H_DATA, E_NONE);
    add(1'b1, 8'h80, SYNC_H_DATA, E_NONE);
    add(1'b1, 8'h90, SYNC_H_DATA, E_NONE);
    add(1'b1, 8'h00, SYNC_H_DATA, E_OSX);
  endtask

  initial begin
    logic [7:0] d;

    // First OS block: leaves Reset, then waits in Os_Wait.
    add_fill(16, 8'hAA, SYNC_H_OS, E_NONE);
    // 1: idles, SDP, six DLLP bytes, idles.
    add_fill(4, 8'h00, SYNC_H_DATA, E_IDLE);
    add(1'b1, 8'hF0, SYNC_H_DATA, E_NONE);
    add(1'b1, 8'hAC, SYNC_H_DATA, E_NONE);
    add_payload(8'h11, 6, 1'b0, 11'd0);
    add_fill(4, 8'h00, SYNC_H_DATA, E_IDLE);
    // 2: STP Length=6, 20 payload bytes crossing into the next block.
    add(1'b1, 8'h6F, SYNC_H_DATA, E_NONE);
    add(1'b1, 8'h00, SYNC_H_DATA, E_NONE);
    add(1'b1, 8'h12, SYNC_H_DATA, E_NONE);
    add(1'b1, 8'h34, SYNC_H_DATA, E_NONE);
    add_payload(8'h40, 20, 1'b1, 11'd6);
    add_fill(4, 8'h00, SYNC_H_DATA, E_IDLE);
    // 3a: EDS at 12..15, then a proper OS block.
    add_eds();
    add_fill(16, 8'hAA, SYNC_H_OS, E_NONE);
    // 3b: EDS again, then a data block: error on its symbol 0.
    add_fill(12, 8'h00, SYNC_H_DATA, E_IDLE);
    add_eds();
    add(1'b1, 8'h00, SYNC_H_DATA, E_ERR);
    add_fill(15, 8'h00, SYNC_H_DATA, E_NONE);
    // 4: recover via OS block, then bad token 55h, recover, clean SDP.
    add_fill(16, 8'hAA, SYNC_H_OS, E_NONE);
    add(1'b1, 8'h00, SYNC_H_DATA, E_IDLE);
    add(1'b1, 8'h55, SYNC_H_DATA, E_ERR);
    add_fill(14, 8'h00, SYNC_H_DATA, E_NONE);
    add_fill(16, 8'hAA, SYNC_H_OS, E_NONE);
    add(1'b1, 8'hF0, SYNC_H_DATA, E_NONE);
    add(1'b1, 8'hAC, SYNC_H_DATA, E_NONE);
    add_payload(8'hA0, 6, 1'b0, 11'd0);
    add_fill(8, 8'h00, SYNC_H_DATA, E_IDLE);
    // STP Length=4 is below the minimum: error on the 4th token symbol.
    add(1'b1, 8'h4F, SYNC_H_DATA, E_NONE);
    add(1'b1, 8'h00, SYNC_H_DATA, E_NONE);
    add(1'b1, 8'h00, SYNC_H_DATA, E_NONE);
    add(1'b1, 8'h00, SYNC_H_DATA, E_ERR);
    add_fill(12, 8'h00, SYNC_H_DATA, E_NONE);
    add_fill(16, 8'hAA, SYNC_H_OS, E_NONE);
    // 5: STP at 7..10, payload 11..15 with a 3-cycle stall, then OS header mid-TLP.
    add_fill(7, 8'h00, SYNC_H_DATA, E_IDLE);
    add(1'b1, 8'h6F, SYNC_H_DATA, E_NONE);
    add(1'b1, 8'h00, SYNC_H_DATA, E_NONE);
    add(1'b1, 8'h12, SYNC_H_DATA, E_NONE);
    add(1'b1, 8'h34, SYNC_H_DATA, E_NONE);
    for (int i = 0; i < 5; i++) begin
      d = 8'hC0 + 8'(i);
      if (i == 3) begin
        for (int s = 0; s < 3; s++) add(1'b0, 8'hFF, SYNC_H_OS, E_NONE);
      end
      add(1'b1, d, SYNC_H_DATA, e_byte(d, i == 0, 1'b0, 1'b1, (i == 0) ? 11'd6 : 11'd0));
    end
    add(1'b1, 8'hAA, SYNC_H_OS, E_ERR_EOP);
    add_fill(15, 8'hAA, SYNC_H_OS, E_NONE);

    // Reset phase.
    RST_L = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outputs", 32'(outs()), 32'(E_NONE));
    chk("reset_state", 32'(o_State), 32'(ST_RESET));
    @(negedge CLK);
    RST_L = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Async reset in the middle of a TLP: no EOP, state back to Reset.
    apply(mk(1'b1, 8'hAA, SYNC_H_OS, 4'd0, E_NONE), "rst_seq_os");
    apply(mk(1'b1, 8'h5F, SYNC_H_DATA, 4'd0, E_NONE), "rst_seq_stp0");
    apply(mk(1'b1, 8'h00, SYNC_H_DATA, 4'd1, E_NONE), "rst_seq_stp1");
    apply(mk(1'b1, 8'h00, SYNC_H_DATA, 4'd2, E_NONE), "rst_seq_stp2");
    apply(mk(1'b1, 8'h00, SYNC_H_DATA, 4'd3, E_NONE), "rst_seq_stp3");
    for (int i = 0; i < 4; i++) begin
      d = 8'hD0 + 8'(i);
      apply(mk(1'b1, d, SYNC_H_DATA, 4'(4 + i),
               e_byte(d, i == 0, 1'b0, 1'b1, (i == 0) ? 11'd5 : 11'd0)), $sformatf("rst_seq_pl%0d", i));
    end
    #2;
    i_EN = 1'b0;
    RST_L = 1'b0;
    #1;
    chk("midpkt_reset_outputs", 32'(outs()), 32'(E_NONE));
    chk("midpkt_reset_state", 32'(o_State), 32'(ST_RESET));
    repeat (2) @(posedge CLK);
    #1;
    chk("midpkt_reset_hold", 32'(outs()), 32'(E_NONE));
    @(negedge CLK);
    RST_L = 1'b1;

    // Clean DLLP after reset, then confirm parser is back in Tokens.
    apply(mk(1'b1, 8'hAA, SYNC_H_OS, 4'd0, E_NONE), "post_rst_os");
    apply(mk(1'b1, 8'hF0, SYNC_H_DATA, 4'd0, E_NONE), "post_rst_sdp0");
    apply(mk(1'b1, 8'hAC, SYNC_H_DATA, 4'd1, E_NONE), "post_rst_sdp1");
    for (int i = 0; i < 6; i++) begin
      d = 8'hE0 + 8'(i);
      apply(mk(1'b1, d, SYNC_H_DATA, 4'(2 + i), e_byte(d, i == 0, i == 5, 1'b0, 11'd0)),
            $sformatf("post_rst_pl%0d", i));
    end
    chk("post_rst_state", 32'(o_State), 32'(ST_TOKENS));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
